frame_drain: RTL and testbench
==============================

# frame_drain

Front-end feeder for the row-delay memories. Accepts a back-pressurable pixel stream with an end-of-frame marker and drives the non-stalling `up_data`/`up_val` input of the line-delay chain. After each frame's last pixel it holds off upstream and injects `cfg_delay` pad pixels. Rows stuck in the delay memories drain to the filter before the next frame enters.

## Interface
- `IMG_WIDTH`, 8, pixel width in bits
- `MEM_AWIDTH`, 12, width of the pad-count (row delay) field; matches the delay memories

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cfg_delay`  in  MEM_AWIDTH  number of pad pixels per frame (row length); 0 = no drain
- `cfg_pad`  in  IMG_WIDTH  pixel value injected during drain
- `cfg_set`  in  1  single-cycle strobe; captures `cfg_delay` and `cfg_pad`
- `up_data`  in  IMG_WIDTH  incoming pixel
- `up_last`  in  1  marks the final pixel of a frame
- `up_val`  in  1  upstream valid
- `up_rdy`  out  1  upstream ready; transfer when `up_val && up_rdy`
- `dn_data`  out  IMG_WIDTH  registered pixel to the delay chain
- `dn_val`  out  1  registered strobe, one pixel per high cycle
- `dn_pad`  out  1  qualifies `dn_val`; 1 = injected pad pixel
- `dn_last`  out  1  with `dn_val`; final pixel of frame including drain
- `busy`  out  1  high while in FLUSH

## Operation
- States: IDLE, PASS, FLUSH. Reset enters IDLE.
- **IDLE:** `up_rdy`=0. `cfg_set` moves to PASS.
- **PASS:** `up_rdy` = !`cfg_set`. Each handshake registers `up_data` to `dn_data` with `dn_val`=1 and `dn_pad`=0.
  - Handshake with `up_last`=1 and `cfg_delay_r`≠0: go to FLUSH and load `cnt` = `cfg_delay_r`−1. `dn_last`=0 on that pixel.
  - Handshake with `up_last`=1 and `cfg_delay_r`=0: stay in PASS. `dn_last`=1 on that pixel.
- **FLUSH:** `up_rdy`=0 and `busy`=1.
  - Every cycle emit `cfg_pad_r` with `dn_val`=1 and `dn_pad`=1.
  - When `cnt`=0, set `dn_last`=1 on that pad and return to PASS. Otherwise `cnt` decrements by 1.
  - `cnt` is MEM_AWIDTH bits. The maximum drain is 2^MEM_AWIDTH−1 pads.
- **`cfg_set`:** has priority in any state.
  - Next edge: `cfg_delay_r`/`cfg_pad_r` load and the state becomes PASS.
  - Any FLUSH in progress is abandoned and `cnt` clears.
  - `dn_val`, `dn_pad` and `dn_last` are 0 in the following cycle.
  - No upstream transfer occurs in the `cfg_set` cycle.
- **Registers captured only by `cfg_set`:** `cfg_delay_r` and `cfg_pad_r`. Their reset value is 0.
- **Cycles with no handshake and not in FLUSH:** `dn_val`=`dn_pad`=`dn_last`=0. `dn_data` holds its last value.

## Timing
- Reset (asynchronous assert, synchronous release): `dn_data`=0, `dn_val`=0, `dn_pad`=0, `dn_last`=0, `busy`=0, `up_rdy`=0, `cnt`=0.
- `up_rdy` and `busy` are combinational from state plus `cfg_set`. All `dn_*` outputs are registered.
- Latency: a handshake in cycle N gives `dn_val` in cycle N+1. Throughput is 1 pixel/cycle.
- Last-pixel handshake in cycle N with D=`cfg_delay_r`≥1:
  - FLUSH and `busy` occupy cycles N+1..N+D.
  - Pads are visible on `dn_*` in cycles N+2..N+D+1.
  - `dn_last` is visible in cycle N+D+1, when `up_rdy` is high again.
- Upstream stalls (`up_val`=0) in PASS create gaps in `dn_val`. FLUSH is never gapped.
- Reset asserted mid-FLUSH: return immediately to IDLE. `cfg_set` is required again.

## Test plan
- **Reset then pixels without `cfg_set`:** `up_rdy` stays 0 and `dn_val` is never asserted.
- **`cfg_set` with `cfg_delay`=4, `cfg_pad`=0x00; frame of 8 pixels 0x10..0x17 with `up_last` on 0x17:**
  - `dn` outputs 0x10..0x17 each one cycle after its handshake, then exactly 4 pads of 0x00 with `dn_pad`=1.
  - `dn_last` is set only on the 4th pad.
  - `up_rdy` is low for exactly 4 cycles.
- **`cfg_delay`=0, two back-to-back 3-pixel frames:** no pads; `dn_last` on pixels 3 and 6; `up_rdy` never drops.
- **Random `up_val` stalls on a 16-pixel frame with D=5, `cfg_pad`=0xFF:** pixel order and count preserved; 5 consecutive 0xFF pads follow the last pixel.
- **`cfg_set` (`cfg_delay`=2) pulsed in the 2nd FLUSH cycle of a D=6 drain:**
  - The drain stops: `dn_val`=0 in the next cycle and `up_rdy` is 0 in the strobe cycle.
  - The next frame drains 2 pads.
- **Reset pulsed during FLUSH:** all outputs are 0 at once; after release the state is IDLE and `up_rdy`=0.

Source files
------------

// File: rtl/frame_drain_if.sv
// Pixel stream bundle between the upstream source, frame_drain and the row-delay chain.
// Latency: none (wires only).
// Backpressure: up_* side is valid/ready; dn_* side is a non-stalling valid strobe.
// Ports:
//   up_data/up_last/up_val -> feeder, up_rdy <- feeder
//   dn_data/dn_val/dn_pad/dn_last <- feeder (registered, one pixel per dn_val cycle)
// Modports: slave = the feeder (frame_drain), master = the surrounding environment.
interface frame_drain_if #(
  parameter int IMG_WIDTH = 8
);
  logic [IMG_WIDTH-1:0] up_data;
  logic                 up_last;
  logic                 up_val;
  logic                 up_rdy;
  logic [IMG_WIDTH-1:0] dn_data;
  logic                 dn_val;
  logic                 dn_pad;
  logic                 dn_last;

  modport slave (
    input  up_data, up_last, up_val,
    output up_rdy,
    output dn_data, dn_val, dn_pad, dn_last
  );

  modport master (
    output up_data, up_last, up_val,
    input  up_rdy,
    input  dn_data, dn_val, dn_pad, dn_last
  );
endinterface

// File: rtl/frame_drain.sv
// Feeds the line-delay chain; after each frame appends cfg_delay pad pixels to flush stuck rows.
// Latency: 1 cycle handshake-to-dn_val; pads follow the last pixel back to back, 1 pixel/cycle.
// Backpressure: up_rdy drops while draining or during cfg_set; dn side never stalls.
// Ports:
//   clk, rst (async, active low)
//   cfg_delay/cfg_pad/cfg_set : pad count and pad value, captured on the cfg_set strobe
//   bus (frame_drain_if.slave) : upstream valid/ready stream in, registered dn_* stream out
//   busy                       : high while pads are being injected
module frame_drain #(
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] cfg_delay,
  input  logic [IMG_WIDTH-1:0]  cfg_pad,
  input  logic                  cfg_set,
  frame_drain_if.slave          bus,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [MEM_AWIDTH-1:0] CNT_ONE = MEM_AWIDTH'(1);

  state_t                state_q, state_d;
  logic [MEM_AWIDTH-1:0] cnt_q, cnt_d;
  logic [MEM_AWIDTH-1:0] cfg_delay_q, cfg_delay_d;
  logic [IMG_WIDTH-1:0]  cfg_pad_q, cfg_pad_d;
  logic [IMG_WIDTH-1:0]  dn_data_q, dn_data_d;
  logic                  dn_val_q, dn_val_d;
  logic                  dn_pad_q, dn_pad_d;
  logic                  dn_last_q, dn_last_d;
  logic                  up_rdy_c;
  logic                  hs;
  logic                  delay_zero;
  logic                  cnt_zero;

  assign hs         = bus.up_val && up_rdy_c;
  assign delay_zero = (cfg_delay_q == '0);
  assign cnt_zero   = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a config strobe overrides everything, including a drain in progress
  always_comb begin
    state_d = state_q;
    if (cfg_set) begin
      state_d = ST_PASS;
    end else begin
      case (state_q)
        ST_PASS:  if (hs && bus.up_last && !delay_zero) state_d = ST_FLUSH;
        ST_FLUSH: if (cnt_zero) state_d = ST_PASS;
        default:  state_d = state_q;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    up_rdy_c    = (state_q == ST_PASS) && !cfg_set;
    busy        = (state_q == ST_FLUSH);
    cnt_d       = cnt_q;
    cfg_delay_d = cfg_delay_q;
    cfg_pad_d   = cfg_pad_q;
    dn_data_d   = dn_data_q;
    dn_val_d    = 1'b0;
    dn_pad_d    = 1'b0;
    dn_last_d   = 1'b0;
    if (cfg_set) begin
      cfg_delay_d = cfg_delay;
      cfg_pad_d   = cfg_pad;
      cnt_d       = '0;
    end else if (hs) begin
      dn_data_d = bus.up_data;
      dn_val_d  = 1'b1;
      // With no drain configured the frame ends on the real pixel itself
      dn_last_d = bus.up_last && delay_zero;
      // cnt counts remaining pads after the current one, so D pads need D-1
      if (bus.up_last && !delay_zero) cnt_d = cfg_delay_q - CNT_ONE;
    end else if (state_q == ST_FLUSH) begin
      dn_data_d = cfg_pad_q;
      dn_val_d  = 1'b1;
      dn_pad_d  = 1'b1;
      if (cnt_zero) dn_last_d = 1'b1;
      else          cnt_d     = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      cfg_delay_q <= '0;
      cfg_pad_q   <= '0;
      dn_data_q   <= '0;
      dn_val_q    <= 1'b0;
      dn_pad_q    <= 1'b0;
      dn_last_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cfg_delay_q <= cfg_delay_d;
      cfg_pad_q   <= cfg_pad_d;
      dn_data_q   <= dn_data_d;
      dn_val_q    <= dn_val_d;
      dn_pad_q    <= dn_pad_d;
      dn_last_q   <= dn_last_d;
    end
  end

  assign bus.up_rdy  = up_rdy_c;
  assign bus.dn_data = dn_data_q;
  assign bus.dn_val  = dn_val_q;
  assign bus.dn_pad  = dn_pad_q;
  assign bus.dn_last = dn_last_q;

endmodule

// File: tb/tb_frame_drain.sv
// Bench for frame_drain: scoreboard of expected dn beats (data, pad, last, cycle).
// Latency: expected beats carry the posedge index at which they must appear.
// Backpressure: driver holds up_val until up_rdy, counting the cycles it was held off.
module tb_frame_drain;

  logic        clk;
  logic        rst;
  logic [11:0] cfg_delay;
  logic [7:0]  cfg_pad;
  logic        cfg_set;
  logic        busy;

  frame_drain_if #(.IMG_WIDTH(8)) bus ();

  frame_drain #(.IMG_WIDTH(8), .MEM_AWIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_delay (cfg_delay),
    .cfg_pad   (cfg_pad),
    .cfg_set   (cfg_set),
    .bus       (bus),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pad;
    logic       last;
    int         stamp;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         m_delay = 0;
  logic [7:0] m_pad = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: every dn_val beat must be the oldest expected one, at its exact cycle
  always @(negedge clk) begin
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        chk("dn_missing", 32'd1, 32'd0);
        void'(exp_q.pop_front());
      end
      if (bus.dn_val) begin
        if (exp_q.size() == 0) begin
          chk("dn_spurious", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dn_data", bus.dn_data, mon_e.d);
          chk("dn_pad", bus.dn_pad, mon_e.pad);
          chk("dn_last", bus.dn_last, mon_e.last);
          chk("dn_cycle", cyc, mon_e.stamp);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.up_val = 1'b0;
    end
  endtask

  task automatic cfg(input logic [11:0] d, input logic [7:0] p, input bit in_flush);
    @(negedge clk);
    bus.up_val = 1'b0;
    cfg_delay  = d;
    cfg_pad    = p;
    cfg_set    = 1'b1;
    #1;
    chk("cfg_rdy_low", bus.up_rdy, 1'b0);
    if (in_flush) chk("cfg_busy_in_flush", busy, 1'b1);
    // Anything scheduled from the strobe edge onward is abandoned
    while (exp_q.size() > 0 && exp_q[$].stamp >= cyc + 1) void'(exp_q.pop_back());
    m_delay = int'(d);
    m_pad   = p;
    @(negedge clk);
    cfg_set = 1'b0;
    chk("cfg_dn_val_zero", bus.dn_val, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int stall_max,
                      output int waits, output int busy_cnt);
    int    k;
    bit    done;
    beat_t b;
    waits    = 0;
    busy_cnt = 0;
    done     = 1'b0;
    k = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
    repeat (k) begin
      @(negedge clk);
      bus.up_val = 1'b0;
    end
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      bus.up_val  = 1'b1;
      bus.up_data = d;
      bus.up_last = last;
      #1;
      if (bus.up_rdy) begin
        done   = 1'b1;
        b.d    = d;
        b.pad  = 1'b0;
        b.last = last && (m_delay == 0);
        b.stamp = cyc + 1;
        exp_q.push_back(b);
        if (last && m_delay != 0) begin
          for (int i = 1; i <= m_delay; i++) begin
            b.d     = m_pad;
            b.pad   = 1'b1;
            b.last  = (i == m_delay);
            b.stamp = cyc + 1 + i;
            exp_q.push_back(b);
          end
        end
      end else begin
        waits++;
        if (busy) busy_cnt++;
      end
    end
    if (!done) begin
      chk("send_timeout", 32'd0, 32'd1);
      bus.up_val = 1'b0;
    end
  endtask

  initial begin
    int w;
    int bc;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
    w = 0; bc = 0;
  end

  initial begin
    int w;
    int bc;
    rst         = 1'b0;
    cfg_delay   = '0;
    cfg_pad     = '0;
    cfg_set     = 1'b0;
    bus.up_val  = 1'b0;
    bus.up_data = '0;
    bus.up_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dn_data", bus.dn_data, 8'h00);
    chk("rst_dn_val", bus.dn_val, 1'b0);
    chk("rst_dn_pad", bus.dn_pad, 1'b0);
    chk("rst_dn_last", bus.dn_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_up_rdy", bus.up_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Pixels offered before any cfg_set are never accepted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.up_val  = 1'b1;
      bus.up_data = 8'(i);
      bus.up_last = (i == 5);
      #1;
      chk("idle_up_rdy", bus.up_rdy, 1'b0);
    end
    idle(2);

    // D=4, pad 0x00, 8-pixel frame 0x10..0x17
    cfg(12'd4, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h10 + i), (i == 7), 0, w, bc);
      chk("t2_pass_waits", w, 0);
    end
    send(8'h18, 1'b1, 0, w, bc);
    chk("t2_rdy_low_cycles", w, 4);
    chk("t2_busy_cycles", bc, 4);
    idle(8);

    // D=0: back-to-back 3-pixel frames, no pads and no holdoff
    cfg(12'd0, 8'h5A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h20 + i), (i == 2 || i == 5), 0, w, bc);
      chk("t3_rdy_never_low", w, 0);
    end
    idle(4);

    // D=5, pad 0xFF, random upstream stalls on a 16-pixel frame
    cfg(12'd5, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i), (i == 15), 3, w, bc);
    send(8'h40, 1'b1, 0, w, bc);
    chk("t4_rdy_low_cycles", w, 5);
    idle(10);

    // D=6 drain interrupted by cfg_set(D=2) in its 2nd flush cycle
    cfg(12'd6, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) send(8'(8'h50 + i), (i == 2), 0, w, bc);
    @(negedge clk);
    bus.up_val = 1'b0;
    chk("t5_busy_flush1", busy, 1'b1);
    cfg(12'd2, 8'h55, 1'b1);
    send(8'h60, 1'b0, 0, w, bc);
    chk("t5_resume_waits", w, 0);
    send(8'h61, 1'b1, 0, w, bc);
    send(8'h62, 1'b1, 0, w, bc);
    chk("t5_new_drain_len", w, 2);
    idle(6);

    // Reset in the middle of a drain
    cfg(12'd6, 8'h11, 1'b0);
    send(8'h70, 1'b0, 0, w, bc);
    send(8'h71, 1'b1, 0, w, bc);
    @(negedge clk);
    bus.up_val = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_dn_data", bus.dn_data, 8'h00);
    chk("mrst_dn_val", bus.dn_val, 1'b0);
    chk("mrst_dn_pad", bus.dn_pad, 1'b0);
    chk("mrst_dn_last", bus.dn_last, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_up_rdy", bus.up_rdy, 1'b0);
    exp_q.delete();
    m_delay = 0;
    m_pad   = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.up_val  = 1'b1;
      bus.up_data = 8'h99;
      bus.up_last = 1'b1;
      #1;
      chk("post_rst_up_rdy", bus.up_rdy, 1'b0);
    end
    idle(2);
    cfg(12'd1, 8'h22, 1'b0);
    send(8'h80, 1'b1, 0, w, bc);
    send(8'h81, 1'b0, 0, w, bc);
    chk("post_rst_drain_len", w, 1);
    idle(8);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
